// File: rtl/matcollect_if.sv
// fixedp: fixed-point parameter carrier and common clock/reset for the matrix library.
//   WIDTH : element width in bits, shared by every block attached to this interface.
//   clk   : single clock, all state updates on its rising edge.
//   reset : synchronous, active-high reset.
// Modports:
//   master : drives clk/reset (clock/reset source, e.g. a testbench or top-level wrapper).
//   slave  : consumes clk/reset (datapath blocks such as matcollect).
interface fixedp #(
  parameter int unsigned WIDTH = 8
);
  logic clk;
  logic reset;

  modport master (output clk, output reset);
  modport slave  (input clk, input reset);
endinterface

// File: rtl/matcollect.sv
// matcollect: assembles a row-major stream of elements into a ROWS x COLS matrix and
// presents it on f with a valid/ready handshake.
//
// Parameters:
//   ROWS, COLS : dimensions of the assembled matrix (both >= 1).
//   WIDTH      : element width; must equal g.WIDTH of the attached fixedp interface.
// Ports:
//   g        : fixedp slave, supplies g.clk and g.reset (synchronous, active-high).
//   in_data  : one matrix element, row-major order.
//   in_valid : in_data is valid.
//   in_ready : element accepted this cycle when high together with in_valid.
//   f        : assembled matrix, f[row][col] with row 1..ROWS, col 1..COLS.
//   f_valid  : f holds a complete matrix.
//   f_ready  : downstream consumes f.
// Optional feature (macro MATCOLLECT_TLAST_EN):
//   in_last  : marks the last element of a matrix.
//   err      : registered one-cycle pulse on a framing mismatch between in_last and the
//              element count.
//
// Two states: FILL accepts elements unconditionally; HOLD presents the completed matrix and
// only passes f_ready through to in_ready, so a new matrix may start in the same cycle the
// old one is consumed (no bubble at full throughput).
module matcollect #(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned WIDTH = 8
) (
  fixedp.slave                             g,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
`ifdef MATCOLLECT_TLAST_EN
  input  logic                             in_last,
  output logic                             err,
`endif
  output logic [ROWS:1][COLS:1][WIDTH-1:0] f,
  output logic                             f_valid,
  input  logic                             f_ready
);

  localparam int unsigned RW = $clog2(ROWS + 1);
  localparam int unsigned CW = $clog2(COLS + 1);

  localparam logic [RW-1:0] RowFirst = RW'(1);
  localparam logic [CW-1:0] ColFirst = CW'(1);
  localparam logic [RW-1:0] RowLast  = RW'(ROWS);
  localparam logic [CW-1:0] ColLast  = CW'(COLS);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e state_q, state_d;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [ROWS:1][COLS:1][WIDTH-1:0] f_q, f_d;
  logic err_q, err_d;

  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          accept;
  logic          at_last;
  logic          last_flag;

`ifdef MATCOLLECT_TLAST_EN
  assign last_flag = in_last;
  assign err       = err_q;
`else
  assign last_flag = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  // A HOLD-state accept can only happen alongside the f handshake, so the write position is
  // always (1,1) there regardless of what the counters hold.
  always_comb begin
    if (state_q == StHold) begin
      cur_row = RowFirst;
      cur_col = ColFirst;
    end else begin
      cur_row = row_q;
      cur_col = col_q;
    end
  end

  assign at_last = (cur_row == RowLast) && (cur_col == ColLast);

  // State register
  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if ((state_q == StHold) && f_ready) begin
      state_d = StFill;
    end
    if (accept && at_last) begin
      state_d = StHold;
    end
  end

  // Outputs decoded from state; in_ready never looks at in_valid.
  always_comb begin
    in_ready = 1'b1;
    f_valid  = 1'b0;
    unique case (state_q)
      StFill: begin
        in_ready = 1'b1;
        f_valid  = 1'b0;
      end
      StHold: begin
        in_ready = f_ready;
        f_valid  = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
        f_valid  = 1'b0;
      end
    endcase
  end

  // Datapath: element write, position counters and framing error.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    f_d   = f_q;
    err_d = 1'b0;

    if ((state_q == StHold) && f_ready) begin
      row_d = RowFirst;
      col_d = ColFirst;
    end

    if (accept) begin
      for (int unsigned r = 1; r <= ROWS; r++) begin
        for (int unsigned c = 1; c <= COLS; c++) begin
          if ((cur_row == RW'(r)) && (cur_col == CW'(c))) begin
            f_d[r][c] = in_data;
          end
        end
      end

      if (at_last) begin
        // Matrix complete; a missing in_last is flagged but the matrix is still delivered.
        row_d = RowFirst;
        col_d = ColFirst;
        err_d = ~last_flag;
`ifndef MATCOLLECT_TLAST_EN
        err_d = 1'b0;
`endif
      end else if (last_flag) begin
        // Early in_last: abandon the partial matrix and restart framing.
        row_d = RowFirst;
        col_d = ColFirst;
        err_d = 1'b1;
      end else if (cur_col == ColLast) begin
        col_d = ColFirst;
        row_d = cur_row + RW'(1);
      end else begin
        row_d = cur_row;
        col_d = cur_col + CW'(1);
      end
    end
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      row_q <= RowFirst;
      col_q <= ColFirst;
      f_q   <= '0;
      err_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      f_q   <= f_d;
      err_q <= err_d;
    end
  end

  assign f = f_q;

`ifndef MATCOLLECT_TLAST_EN
  // err_q is only observable with the in_last feature; keep it tied off otherwise.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/matcollect.md
MATCOLLECT -- requirements
Module: matcollect

Interface
REQ-001 SHALL have parameter ROWS, default 1: row count of the assembled output matrix.
REQ-002 SHALL have parameter COLS, default 1: column count of the assembled output matrix.
REQ-003 SHALL have port g, interface fixedp: fixed-point parameters and common ports; element width is g.WIDTH.
REQ-004 SHALL have g.clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have g.reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have in_data, input, g.WIDTH bits: one matrix element, row-major stream order.
REQ-007 SHALL have in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 SHALL have f, output, [ROWS:1][COLS:1][g.WIDTH-1:0]: the assembled matrix, indexed like all matrix ports in the library.
REQ-010 SHALL have f_valid, output, 1 bit: f holds a complete matrix.
REQ-011 SHALL have f_ready, input, 1 bit: the downstream stage (e.g. a column selector) consumes f.

Function
REQ-012 SHALL treat an element as accepted when in_valid and in_ready are both high at a rising edge.
REQ-013 SHALL keep a row counter (1..ROWS) and a column counter (1..COLS), both starting at (1,1).
REQ-014 SHALL write each accepted element to f[row][col], then advance: col+1; at col=COLS, wrap col to 1 and advance row+1.
REQ-015 SHALL use two states: FILL and HOLD.
REQ-016 In FILL: in_ready=1 and f_valid=0.
REQ-017 In FILL, accepting element (ROWS,COLS) SHALL move the block to HOLD, so f_valid=1 on the next cycle (latency 1 cycle from the last element).
REQ-018 In HOLD: f_valid=1; f SHALL stay bit-stable until handshake; in_ready = f_ready (combinational pass-through).
REQ-019 In HOLD with f_ready=1: SHALL return to FILL with counters at (1,1); an element accepted in the same cycle SHALL be written to f[1][1], leaving counters at (1,2).
REQ-020 If ROWS=COLS=1, an element accepted in HOLD with f_ready=1 SHALL complete a new matrix, and the block SHALL stay in HOLD.
REQ-021 In HOLD with f_ready=0, in_ready SHALL be 0 and no element is written.
REQ-022 Sustained throughput SHALL be one element per cycle with no bubble between matrices when f_ready is held high.
REQ-023 f_valid and in_ready SHALL not depend on in_valid.

Reset
REQ-024 g.reset high at a rising edge SHALL set: state FILL, counters (1,1), f all zero, f_valid 0 (err 0 when configured).
REQ-025 Reset mid-matrix or in HOLD SHALL discard the partial or undelivered matrix; no element is accepted on a reset cycle.

Configuration
REQ-026 Macro MATCOLLECT_TLAST_EN, when defined, SHALL add input in_last (1 bit, qualifies in_data) and output err (1 bit, registered, one-cycle pulse).
REQ-027 With MATCOLLECT_TLAST_EN: an accepted element with in_last=1 before position (ROWS,COLS) SHALL pulse err, reset counters to (1,1), stay in FILL, and deliver no matrix.
REQ-028 With MATCOLLECT_TLAST_EN: an accepted element at (ROWS,COLS) with in_last=0 SHALL pulse err, and the matrix SHALL still be delivered.
REQ-029 Without MATCOLLECT_TLAST_EN: ports in_last and err SHALL be absent; framing is by count only.

Verification
REQ-030 ROWS=2, COLS=3: stream 1..6 with in_valid high, f_ready low -> f_valid=1 one cycle after 6th accept, f=[[1,2,3],[4,5,6]], in_ready=0.
REQ-031 Same setup, f_ready held high, stream 1..12 back-to-back -> in_ready never low, f_valid pulses on two cycles, second f=[[7,8,9],[10,11,12]].
REQ-032 ROWS=COLS=1, in_valid and f_ready high continuously, data 5,6,7 -> state stays HOLD, f shows 5,6,7 on consecutive cycles.
REQ-033 Reset after 4 of 6 elements, then stream 9..14 -> f=[[9,10,11],[12,13,14]], no stale data.
REQ-034 MATCOLLECT_TLAST_EN, in_last=1 on the 3rd element -> err pulses 1 cycle, no f_valid; next 6 elements form a correct matrix.
REQ-035 MATCOLLECT_TLAST_EN, 6th element with in_last=0 -> err pulse, and f_valid still asserts with the full matrix.
